// File: rtl/column_window_former.sv
// Column-to-window former: slides buffered columns into a ROWS x 5 window with border padding (WIN_EDGE_REPLICATE_EN selects edge replication over zero fill).
// Latency: the window for centre c is presented one clk after the en that shifts in column c+2; all outputs are registered.
// Backpressure: none; everything advances only on en and holds otherwise, including rd_addr.
module column_window_former #(
    parameter int PIX_W  = 16,
    parameter int ROWS   = 5,
    parameter int IMG_W  = 450,
    parameter int AWIDTH = 9,
    parameter int DEPTH  = 512,
    parameter int LAG    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      line_start,
    input  logic [ROWS*PIX_W-1:0]     col_in,
    output logic [AWIDTH-1:0]         rd_addr,
    output logic [5*ROWS*PIX_W-1:0]   win_out,
    output logic                      win_valid,
    output logic [AWIDTH-1:0]         x_out,
    output logic                      line_err
);

    localparam int CW = ROWS * PIX_W;
    localparam int NW = $clog2(IMG_W + 1);
    localparam logic [AWIDTH-1:0] RD_RST = AWIDTH'((DEPTH - LAG) % DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t               r_state, w_state_nxt;
    logic [NW-1:0]        r_cnt, w_cnt_nxt;
    logic                 r_fcnt, w_fcnt_nxt;
    logic [4:0][CW-1:0]   r_win;
    logic [AWIDTH-1:0]    r_rd_addr, r_x;
    logic                 r_vld, r_err;
    logic                 w_load, w_shift, w_flush, w_issue, w_restart;
    logic [AWIDTH-1:0]    w_x_nxt;
    logic [CW-1:0]        w_pad_in, w_pad_w4;

`ifdef WIN_EDGE_REPLICATE_EN
    assign w_pad_in = col_in;
    assign w_pad_w4 = r_win[4];
`else
    assign w_pad_in = '0;
    assign w_pad_w4 = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_fcnt  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fcnt_nxt  = r_fcnt;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_flush     = 1'b0;
        w_issue     = 1'b0;
        w_restart   = 1'b0;
        w_x_nxt     = r_x;
        if (en) begin
            if (line_start) begin
                // A line_start outside IDLE abandons the line in flight.
                w_load      = 1'b1;
                w_restart   = (r_state != S_IDLE);
                w_cnt_nxt   = NW'(1);
                w_fcnt_nxt  = 1'b0;
                w_state_nxt = S_RUN;
            end else begin
                unique case (r_state)
                    S_RUN: begin
                        w_shift   = 1'b1;
                        w_cnt_nxt = r_cnt + NW'(1);
                        if (r_cnt >= NW'(2)) begin
                            w_issue = 1'b1;
                            w_x_nxt = AWIDTH'(r_cnt) - AWIDTH'(2);
                        end
                        if (w_cnt_nxt == NW'(IMG_W)) begin
                            w_state_nxt = S_FLUSH;
                            w_fcnt_nxt  = 1'b0;
                        end
                    end
                    S_FLUSH: begin
                        w_flush    = 1'b1;
                        w_issue    = 1'b1;
                        w_x_nxt    = AWIDTH'(IMG_W - 2) + AWIDTH'(r_fcnt);
                        w_fcnt_nxt = 1'b1;
                        if (r_fcnt) begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_addr <= RD_RST;
            r_win     <= '0;
            r_vld     <= 1'b0;
            r_x       <= '0;
            r_err     <= 1'b0;
        end else begin
            r_vld <= w_issue;
            if (en)
                r_rd_addr <= (r_rd_addr == AWIDTH'(DEPTH - 1)) ? '0 : r_rd_addr + AWIDTH'(1);
            if (w_restart)
                r_err <= 1'b1;
            if (w_issue)
                r_x <= w_x_nxt;
            if (w_load) begin
                for (int i = 0; i < 4; i++)
                    r_win[i] <= w_pad_in;
                r_win[4] <= col_in;
            end else if (w_shift || w_flush) begin
                for (int i = 0; i < 4; i++)
                    r_win[i] <= r_win[i+1];
                r_win[4] <= w_flush ? w_pad_w4 : col_in;
            end
        end
    end

    assign rd_addr   = r_rd_addr;
    assign win_out   = r_win;
    assign win_valid = r_vld;
    assign x_out     = r_x;
    assign line_err  = r_err;

endmodule

// File: tb/tb_column_window_former.sv
// Directed bench for column_window_former with an 8-column line; padding expectations follow WIN_EDGE_REPLICATE_EN.
module tb_column_window_former;

    localparam int PIX_W  = 16;
    localparam int ROWS   = 5;
    localparam int IMG_W  = 8;
    localparam int AWIDTH = 9;
    localparam int DEPTH  = 512;
    localparam int CW     = ROWS * PIX_W;
    localparam int WW     = 5 * CW;

    logic              clk, rst, en, line_start;
    logic [CW-1:0]     col_in;
    logic [AWIDTH-1:0] rd_addr, x_out;
    logic [WW-1:0]     win_out;
    logic              win_valid, line_err;

    int total = 0;
    int bad   = 0;
    int exp_addr, exp_x, nwin;
    bit exp_err;

    column_window_former #(
        .PIX_W(PIX_W), .ROWS(ROWS), .IMG_W(IMG_W),
        .AWIDTH(AWIDTH), .DEPTH(DEPTH), .LAG(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .line_start(line_start), .col_in(col_in),
        .rd_addr(rd_addr), .win_out(win_out), .win_valid(win_valid),
        .x_out(x_out), .line_err(line_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [CW-1:0] mkcol(input int v);
        logic [CW-1:0] c;
        for (int r = 0; r < ROWS; r++) c[r*PIX_W +: PIX_W] = v[PIX_W-1:0];
        return c;
    endfunction

    // Expected window: slot j holds column centre-2+j, out-of-line slots take the border value.
    function automatic logic [WW-1:0] exp_win(input int base, input int centre);
        logic [WW-1:0] w;
        int k, pv, pl, pr;
`ifdef WIN_EDGE_REPLICATE_EN
        pl = base;
        pr = base + IMG_W - 1;
`else
        pl = 0;
        pr = 0;
`endif
        for (int j = 0; j < 5; j++) begin
            k  = centre - 2 + j;
            pv = (k < 0) ? pl : (k >= IMG_W) ? pr : base + k;
            w[j*CW +: CW] = mkcol(pv);
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input bit e, input bit ls, input int v, input bit ev, input int ec, input int base);
        @(negedge clk);
        en = e; line_start = ls; col_in = mkcol(v);
        @(posedge clk);
        #1;
        if (e) exp_addr = (exp_addr + 1) % DEPTH;
        chk("rd_addr", WW'(rd_addr), WW'(exp_addr));
        chk("line_err", WW'(line_err), WW'(exp_err));
        chk("win_valid", WW'(win_valid), WW'(ev));
        if (ev) begin
            chk("x_out", WW'(x_out), WW'(ec));
            chk("win_out", win_out, exp_win(base, ec));
            exp_x = ec;
            nwin++;
        end else begin
            chk("x_hold", WW'(x_out), WW'(exp_x));
        end
    endtask

    // Drives steps s0..s1-1 of a line: columns 0..IMG_W-1 then two flush steps with junk on col_in.
    task automatic run_line(input int base, input int s0, input int s1, input bit gap);
        for (int s = s0; s < s1; s++) begin
            step(1'b1, s == 0, (s < IMG_W) ? base + s : 'hBEEF, s >= 2, s - 2, base);
            if (gap) step(1'b0, 1'b1, 'h5A5A, 1'b0, 0, base);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; line_start = 1'b0; col_in = '0;
        exp_addr = 510; exp_x = 0; exp_err = 1'b0; nwin = 0;
        #12;
        chk("rst_rd_addr", WW'(rd_addr), WW'(510));
        chk("rst_win_out", win_out, '0);
        chk("rst_win_valid", WW'(win_valid), '0);
        chk("rst_x_out", WW'(x_out), '0);
        chk("rst_line_err", WW'(line_err), '0);
        @(negedge clk);
        rst = 1'b0;

        // Basic line, then an idle en without line_start must be ignored.
        run_line(1, 0, IMG_W + 2, 1'b0);
        chk("nwin_basic", WW'(nwin), WW'(8));
        step(1'b1, 1'b0, 'h77, 1'b0, 0, 1);
        step(1'b0, 1'b0, 0, 1'b0, 0, 1);

        // Back-to-back lines.
        nwin = 0;
        run_line('h10, 0, IMG_W + 2, 1'b0);
        run_line('h20, 0, IMG_W + 2, 1'b0);
        chk("nwin_b2b", WW'(nwin), WW'(16));
        chk("b2b_no_err", WW'(line_err), '0);

        // Gapped enable, with line_start asserted on the idle cycles.
        nwin = 0;
        run_line('h30, 0, IMG_W + 2, 1'b1);
        chk("nwin_gap", WW'(nwin), WW'(8));

        // Early line_start at column 4 abandons the old line after centre 1.
        nwin = 0;
        run_line('h40, 0, 4, 1'b0);
        chk("nwin_early_old", WW'(nwin), WW'(2));
        exp_err = 1'b1;
        nwin = 0;
        run_line('h50, 0, IMG_W + 2, 1'b0);
        chk("nwin_early_new", WW'(nwin), WW'(8));

        // Asynchronous reset in the middle of a line.
        run_line('h60, 0, 4, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_rd_addr", WW'(rd_addr), WW'(510));
        chk("mid_rst_win_out", win_out, '0);
        chk("mid_rst_win_valid", WW'(win_valid), '0);
        chk("mid_rst_x_out", WW'(x_out), '0);
        chk("mid_rst_line_err", WW'(line_err), '0);
        en = 1'b0; line_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_addr = 510; exp_x = 0; exp_err = 1'b0; nwin = 0;
        run_line('h70, 0, IMG_W + 2, 1'b0);
        chk("nwin_after_rst", WW'(nwin), WW'(8));
        step(1'b0, 1'b0, 0, 1'b0, 0, 'h70);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
